// File: rtl/edc_scrub_arb.sv
// Arbiter between CPU Wishbone traffic and a background memory scrubber in front of an EDC memory stage.
// Define EDC_SCRUB_EN to build the scrub engine; without it the block is a zero-latency pass-through.
module edc_scrub_arb #(
    parameter int unsigned MAIN_MSB       = 26,
    parameter int unsigned SCRUB_INTERVAL = 1024
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [31:0]  i_wb_adr,
    input  logic [15:0]  i_wb_sel,
    input  logic         i_wb_we,
    input  logic [127:0] i_wb_dat,
    output logic [127:0] o_wb_dat,
    input  logic         i_wb_cyc,
    input  logic         i_wb_stb,
    output logic         o_wb_ack,
    output logic         o_wb_err,
    output logic [31:0]  o_m_adr,
    output logic [15:0]  o_m_sel,
    output logic         o_m_we,
    output logic [127:0] o_m_dat,
    input  logic [127:0] i_m_dat,
    output logic         o_m_cyc,
    output logic         o_m_stb,
    input  logic         i_m_ack,
    input  logic         i_m_err,
    input  logic         i_scrub_en,
    output logic [15:0]  o_scrub_err_cnt,
    output logic         o_scrub_pass
);

`ifdef EDC_SCRUB_EN

    localparam int unsigned LINE_W = MAIN_MSB - 3;
    localparam int unsigned CNT_W  = (SCRUB_INTERVAL > 1) ? $clog2(SCRUB_INTERVAL) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SCRUB_INTERVAL - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CPU  = 2'd1,
        SRD  = 2'd2,
        SWR  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [LINE_W-1:0]   scrub_line;
    logic [CNT_W-1:0]    ivl_cnt;
    logic [15:0]         err_cnt;
    logic                pass;
    logic [127:0]        line_buf;
    logic [31:0]         scrub_adr;
    logic                line_adv;
    logic                err_inc;
    logic                buf_load;

    // Scrub address is a line index; the low nibble and bits above MAIN_MSB stay zero.
    assign scrub_adr = 32'({scrub_line, 4'b0000});

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_m_adr   = '0;
        o_m_sel   = '0;
        o_m_we    = 1'b0;
        o_m_dat   = '0;
        o_m_cyc   = 1'b0;
        o_m_stb   = 1'b0;
        o_wb_dat  = '0;
        o_wb_ack  = 1'b0;
        o_wb_err  = 1'b0;
        line_adv  = 1'b0;
        err_inc   = 1'b0;
        buf_load  = 1'b0;
        case (state)
            IDLE: begin
                if (i_wb_cyc && i_wb_stb) begin
                    state_nxt = CPU;
                end else if ((ivl_cnt == '0) && i_scrub_en) begin
                    state_nxt = SRD;
                end
            end
            CPU: begin
                o_m_adr  = i_wb_adr;
                o_m_sel  = i_wb_sel;
                o_m_we   = i_wb_we;
                o_m_dat  = i_wb_dat;
                o_m_cyc  = i_wb_cyc;
                o_m_stb  = i_wb_stb;
                o_wb_dat = i_m_dat;
                o_wb_ack = i_m_ack;
                o_wb_err = i_m_err;
                // A master abandoning its cycle must not lock out the scrubber.
                if (i_m_ack || i_m_err || !i_wb_cyc) begin
                    state_nxt = IDLE;
                end
            end
            SRD: begin
                o_m_cyc = 1'b1;
                o_m_stb = 1'b1;
                o_m_sel = 16'hFFFF;
                o_m_adr = scrub_adr;
                if (i_m_err) begin
                    err_inc   = 1'b1;
                    line_adv  = 1'b1;
                    state_nxt = IDLE;
                end else if (i_m_ack) begin
                    buf_load  = 1'b1;
                    state_nxt = SWR;
                end
            end
            SWR: begin
                o_m_cyc = 1'b1;
                o_m_stb = 1'b1;
                o_m_we  = 1'b1;
                o_m_sel = 16'hFFFF;
                o_m_adr = scrub_adr;
                o_m_dat = line_buf;
                if (i_m_ack || i_m_err) begin
                    line_adv  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Scrub datapath: line pointer, interval timer, error tally and write-back buffer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            scrub_line <= '0;
            ivl_cnt    <= CNT_LOAD;
            err_cnt    <= '0;
            pass       <= 1'b0;
            line_buf   <= '0;
        end else begin
            pass <= line_adv && (scrub_line == '1);
            if (line_adv) begin
                scrub_line <= scrub_line + LINE_W'(1);
            end
            if (line_adv) begin
                ivl_cnt <= CNT_LOAD;
            end else if ((state == IDLE) && (ivl_cnt != '0)) begin
                ivl_cnt <= ivl_cnt - CNT_W'(1);
            end
            if (err_inc && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end
            if (buf_load) begin
                line_buf <= i_m_dat;
            end
        end
    end

    assign o_scrub_err_cnt = err_cnt;
    assign o_scrub_pass    = pass;

`else

    logic unused_sig;

    assign o_m_adr         = i_wb_adr;
    assign o_m_sel         = i_wb_sel;
    assign o_m_we          = i_wb_we;
    assign o_m_dat         = i_wb_dat;
    assign o_m_cyc         = i_wb_cyc;
    assign o_m_stb         = i_wb_stb;
    assign o_wb_dat        = i_m_dat;
    assign o_wb_ack        = i_m_ack;
    assign o_wb_err        = i_m_err;
    assign o_scrub_err_cnt = '0;
    assign o_scrub_pass    = 1'b0;

    // Clock, reset and scrub controls have no function without the scrub engine.
    assign unused_sig = ^{i_clk, i_rst, i_scrub_en, 32'(MAIN_MSB), 32'(SCRUB_INTERVAL)};

`endif

endmodule

// File: tb/tb_edc_scrub_arb.sv
// Directed scoreboard bench for edc_scrub_arb; covers the scrub build (EDC_SCRUB_EN) or the pass-through build.
module tb_edc_scrub_arb;

    localparam int unsigned MAIN_MSB       = 5;
    localparam int unsigned SCRUB_INTERVAL = 4;

    logic         i_clk      = 1'b0;
    logic         i_rst      = 1'b1;
    logic [31:0]  i_wb_adr   = '0;
    logic [15:0]  i_wb_sel   = '0;
    logic         i_wb_we    = 1'b0;
    logic [127:0] i_wb_dat   = '0;
    logic         i_wb_cyc   = 1'b0;
    logic         i_wb_stb   = 1'b0;
    logic [127:0] i_m_dat    = '0;
    logic         i_m_ack    = 1'b0;
    logic         i_m_err    = 1'b0;
    logic         i_scrub_en = 1'b0;
    logic [127:0] o_wb_dat;
    logic         o_wb_ack;
    logic         o_wb_err;
    logic [31:0]  o_m_adr;
    logic [15:0]  o_m_sel;
    logic         o_m_we;
    logic [127:0] o_m_dat;
    logic         o_m_cyc;
    logic         o_m_stb;
    logic [15:0]  o_scrub_err_cnt;
    logic         o_scrub_pass;

    always #5 i_clk = ~i_clk;

    edc_scrub_arb #(
        .MAIN_MSB       (MAIN_MSB),
        .SCRUB_INTERVAL (SCRUB_INTERVAL)
    ) dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .i_wb_adr        (i_wb_adr),
        .i_wb_sel        (i_wb_sel),
        .i_wb_we         (i_wb_we),
        .i_wb_dat        (i_wb_dat),
        .o_wb_dat        (o_wb_dat),
        .i_wb_cyc        (i_wb_cyc),
        .i_wb_stb        (i_wb_stb),
        .o_wb_ack        (o_wb_ack),
        .o_wb_err        (o_wb_err),
        .o_m_adr         (o_m_adr),
        .o_m_sel         (o_m_sel),
        .o_m_we          (o_m_we),
        .o_m_dat         (o_m_dat),
        .i_m_dat         (i_m_dat),
        .o_m_cyc         (o_m_cyc),
        .o_m_stb         (o_m_stb),
        .i_m_ack         (i_m_ack),
        .i_m_err         (i_m_err),
        .i_scrub_en      (i_scrub_en),
        .o_scrub_err_cnt (o_scrub_err_cnt),
        .o_scrub_pass    (o_scrub_pass)
    );

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        string        tag;
        logic [191:0] val;
    } exp_t;

    exp_t sb[$];

    // Memory contents model: every line returns a distinct address-derived pattern.
    function automatic logic [127:0] mdl(input logic [31:0] a);
        return {a ^ 32'hDEADBEEF, a + 32'h00001111, ~a, a ^ 32'h5A5A5A5A};
    endfunction

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic sb_push(input string tag, input logic [191:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic sb_check(input logic [191:0] obs);
        exp_t e;
        if (sb.size() == 0) begin
            n_total++;
            $error("FAIL sb_underflow: observed %0h expected nothing", obs);
        end else begin
            e = sb.pop_front();
            chk(e.tag, obs, e.val);
        end
    endtask

`ifdef EDC_SCRUB_EN

    int           txn_done = 0;
    logic         rq       = 1'b0;
    logic         rq_we    = 1'b0;
    logic [31:0]  rq_adr   = '0;
    logic [31:0]  err_adr  = 32'h20;

    function automatic logic [191:0] txn(input logic err, input logic we, input logic [31:0] adr,
                                         input logic [15:0] sel, input logic [127:0] dat);
        return 192'({err, we, adr, sel, dat});
    endfunction

    // Memory stage model: request sampled mid-cycle, single-cycle ack (or err on the poisoned line) next edge.
    always @(negedge i_clk) begin
        rq     = o_m_cyc && o_m_stb && !i_m_ack && !i_m_err;
        rq_we  = o_m_we;
        rq_adr = o_m_adr;
    end

    always @(posedge i_clk) begin
        i_m_ack <= 1'b0;
        i_m_err <= 1'b0;
        if (rq && !i_rst) begin
            if (!rq_we && (rq_adr == err_adr)) i_m_err <= 1'b1;
            else                               i_m_ack <= 1'b1;
            i_m_dat <= rq_we ? 128'h0 : mdl(rq_adr);
        end
    end

    // Advance one cycle and score any memory-side transaction completing in it.
    task automatic step();
        @(negedge i_clk);
        if (o_m_cyc && o_m_stb && (i_m_ack || i_m_err)) begin
            sb_check(txn(i_m_err, o_m_we, o_m_adr, o_m_sel, o_m_we ? o_m_dat : 128'h0));
            txn_done++;
        end
    endtask

    task automatic wait_txns(input int k, input string tag);
        int n = 0;
        while ((txn_done < k) && (n < 200)) begin
            step();
            n++;
        end
        if (txn_done < k) begin
            n_total++;
            $error("FAIL %s: observed %0d transactions, required %0d before timeout", tag, txn_done, k);
        end
    endtask

    task automatic wait_stb(output int n);
        n = 0;
        while (!o_m_stb && (n < 200)) begin
            step();
            n++;
        end
    endtask

    task automatic wait_wb_ack(input string tag);
        int n = 0;
        while (!o_wb_ack && !o_wb_err && (n < 50)) begin
            step();
            n++;
        end
        if (!o_wb_ack && !o_wb_err) begin
            n_total++;
            $error("FAIL %s: observed no CPU ack, required ack before timeout", tag);
        end
    endtask

    task automatic cpu_drop();
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        i_wb_adr = '0;
        i_wb_sel = '0;
        i_wb_dat = '0;
    endtask

    initial begin
        int n;
        int busy;
        logic [127:0] wdat;
        wdat       = 128'h0123456789ABCDEF_FEDCBA9876543210;
        i_scrub_en = 1'b1;
        step();
        step();
        chk("rst_m_cyc_stb", 192'({o_m_cyc, o_m_stb}), 192'(2'b00));
        chk("rst_err_cnt", 192'(o_scrub_err_cnt), 192'(16'h0));
        chk("rst_pass", 192'(o_scrub_pass), 192'(1'b0));
        chk("rst_wb_ack", 192'({o_wb_ack, o_wb_err}), 192'(2'b00));

        sb_push("scrub_rd_00", txn(1'b0, 1'b0, 32'h00, 16'hFFFF, 128'h0));
        sb_push("scrub_wr_00", txn(1'b0, 1'b1, 32'h00, 16'hFFFF, mdl(32'h00)));
        i_rst = 1'b0;
        wait_stb(n);
        chk("gap_first", 192'(n), 192'(4));
        wait_txns(2, "wait_line_00");
        step();

        sb_push("scrub_rd_10", txn(1'b0, 1'b0, 32'h10, 16'hFFFF, 128'h0));
        sb_push("scrub_wr_10", txn(1'b0, 1'b1, 32'h10, 16'hFFFF, mdl(32'h10)));
        wait_stb(n);
        chk("gap_10", 192'(n), 192'(4));
        wait_txns(4, "wait_line_10");
        chk("err_cnt_before", 192'(o_scrub_err_cnt), 192'(16'h0));
        step();

        sb_push("scrub_rd_20_err", txn(1'b1, 1'b0, 32'h20, 16'hFFFF, 128'h0));
        wait_txns(5, "wait_line_20");
        step();
        chk("err_cnt_after", 192'(o_scrub_err_cnt), 192'(16'h1));
        chk("no_wb_after_err", 192'(o_m_cyc), 192'(1'b0));

        // Raise a CPU read exactly when the interval timer reaches zero.
        step();
        step();
        step();
        i_wb_adr = 32'h100;
        i_wb_sel = 16'hFFFF;
        i_wb_we  = 1'b0;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        sb_push("cpu_rd_100", txn(1'b0, 1'b0, 32'h100, 16'hFFFF, 128'h0));
        step();
        chk("cpu_grant", 192'({o_m_stb, o_m_we, o_m_adr}), 192'({1'b1, 1'b0, 32'h100}));
        wait_wb_ack("cpu_rd_ack");
        chk("cpu_rd_dat", 192'(o_wb_dat), 192'(mdl(32'h100)));
        cpu_drop();

        sb_push("scrub_rd_30", txn(1'b0, 1'b0, 32'h30, 16'hFFFF, 128'h0));
        sb_push("scrub_wr_30", txn(1'b0, 1'b1, 32'h30, 16'hFFFF, mdl(32'h30)));
        wait_stb(n);
        chk("scrub_after_cpu", 192'({n[7:0], o_m_adr}), 192'({8'd2, 32'h30}));
        wait_txns(7, "wait_rd_30");
        step();

        // CPU write arrives while the scrub write-back is outstanding.
        i_wb_adr = 32'h200;
        i_wb_sel = 16'h0F0F;
        i_wb_we  = 1'b1;
        i_wb_dat = wdat;
        i_wb_cyc = 1'b1;
        i_wb_stb = 1'b1;
        sb_push("cpu_wr_200", txn(1'b0, 1'b1, 32'h200, 16'h0F0F, wdat));
        chk("hold_swr_a", 192'({o_wb_ack, o_wb_err, o_m_we, o_m_adr}), 192'({2'b00, 1'b1, 32'h30}));
        step();
        chk("hold_swr_b", 192'({o_wb_ack, o_wb_err}), 192'(2'b00));
        step();
        chk("wrap_pass", 192'(o_scrub_pass), 192'(1'b1));
        chk("cpu_wait_idle", 192'(o_m_stb), 192'(1'b0));
        step();
        chk("cpu_wr_grant", 192'({o_m_stb, o_m_we, o_m_adr, o_m_sel, o_m_dat}),
            192'({1'b1, 1'b1, 32'h200, 16'h0F0F, wdat}));
        chk("pass_one_cycle", 192'(o_scrub_pass), 192'(1'b0));
        wait_wb_ack("cpu_wr_ack");
        cpu_drop();

        // Reset in the middle of a scrub read abandons the line.
        wait_stb(n);
        chk("pre_rst_adr", 192'({o_m_we, o_m_adr}), 192'({1'b0, 32'h00}));
        i_rst = 1'b1;
        step();
        chk("rst_drop_stb", 192'({o_m_cyc, o_m_stb}), 192'(2'b00));
        chk("rst_clr_err_cnt", 192'(o_scrub_err_cnt), 192'(16'h0));
        i_rst = 1'b0;
        sb_push("scrub_rd_00b", txn(1'b0, 1'b0, 32'h00, 16'hFFFF, 128'h0));
        sb_push("scrub_wr_00b", txn(1'b0, 1'b1, 32'h00, 16'hFFFF, mdl(32'h00)));
        wait_stb(n);
        chk("rst_gap", 192'({n[7:0], o_m_adr}), 192'({8'd4, 32'h00}));

        // Disabling mid-line lets the line finish but starts nothing new.
        i_scrub_en = 1'b0;
        wait_txns(11, "wait_final_line");
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_m_cyc) busy++;
        end
        chk("no_scrub_disabled", 192'(busy), 192'(0));
        chk("sb_drained", 192'(sb.size()), 192'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

`else

    // Drive one vector and score both directions of the pass-through after settling.
    task automatic pt_vec(input logic [31:0] adr, input logic [15:0] sel, input logic we,
                          input logic [127:0] dat, input logic cyc, input logic stb,
                          input logic [127:0] mdat, input logic mack, input logic merr);
        i_wb_adr = adr;
        i_wb_sel = sel;
        i_wb_we  = we;
        i_wb_dat = dat;
        i_wb_cyc = cyc;
        i_wb_stb = stb;
        i_m_dat  = mdat;
        i_m_ack  = mack;
        i_m_err  = merr;
        sb_push("pt_mem_side", 192'({cyc, stb, we, adr, sel, dat}));
        sb_push("pt_cpu_side", 192'({mack, merr, mdat}));
        #1;
        sb_check(192'({o_m_cyc, o_m_stb, o_m_we, o_m_adr, o_m_sel, o_m_dat}));
        sb_check(192'({o_wb_ack, o_wb_err, o_wb_dat}));
        @(negedge i_clk);
    endtask

    initial begin
        int bad;
        repeat (2) @(negedge i_clk);
        chk("rst_err_cnt", 192'(o_scrub_err_cnt), 192'(16'h0));
        chk("rst_pass", 192'(o_scrub_pass), 192'(1'b0));
        i_rst = 1'b0;

        pt_vec(32'h100, 16'hFFFF, 1'b0, 128'h0, 1'b1, 1'b1, mdl(32'h100), 1'b1, 1'b0);
        pt_vec(32'h200, 16'h0F0F, 1'b1, 128'hCAFEF00D_00000000_12345678_9ABCDEF0,
               1'b1, 1'b1, 128'h0, 1'b0, 1'b1);
        pt_vec(32'h0, 16'h0, 1'b0, 128'h0, 1'b0, 1'b0, 128'h0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            pt_vec($urandom, 16'($urandom), 1'($urandom),
                   {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 1'($urandom),
                   {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), 1'($urandom));
        end

        // Without the scrub engine an enabled scrubber must never touch the memory side.
        pt_vec(32'h0, 16'h0, 1'b0, 128'h0, 1'b0, 1'b0, 128'h0, 1'b0, 1'b0);
        i_scrub_en = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge i_clk);
            if (o_m_cyc || o_m_stb || o_scrub_pass || (o_scrub_err_cnt != 16'h0)) bad++;
        end
        chk("pt_no_scrub", 192'(bad), 192'(0));
        chk("sb_drained", 192'(sb.size()), 192'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

`endif

endmodule

// File: doc/edc_scrub_arb.md
EDC_SCRUB_ARB -- requirements
Module: edc_scrub_arb

Interface
REQ-001 SHALL have parameter MAIN_MSB, default 26, meaning MSB of the byte address range scrubbed (0 .. 2^(MAIN_MSB+1)-1).
REQ-002 SHALL have parameter SCRUB_INTERVAL, default 1024, meaning idle clocks between consecutive line scrubs (minimum 1).
REQ-003 SHALL have ports, one clock, reset synchronous active-high:
  i_clk            in   1    clock, all logic on rising edge
  i_rst            in   1    synchronous active-high reset
  i_wb_adr         in   32   CPU-side address
  i_wb_sel         in   16   CPU-side byte select
  i_wb_we          in   1    CPU-side write enable
  i_wb_dat         in   128  CPU-side write data
  o_wb_dat         out  128  CPU-side read data
  i_wb_cyc/i_wb_stb in  1    CPU-side cycle/strobe
  o_wb_ack/o_wb_err out 1    CPU-side ack/error
  o_m_adr          out  32   address to EDC memory stage
  o_m_sel          out  16   byte select to EDC memory stage
  o_m_we           out  1    write enable to EDC memory stage
  o_m_dat          out  128  write data to EDC memory stage
  i_m_dat          in   128  corrected read data from EDC memory stage
  o_m_cyc/o_m_stb  out  1    cycle/strobe to EDC memory stage
  i_m_ack/i_m_err  in   1    ack/error (uncorrectable) from EDC memory stage
  i_scrub_en       in   1    scrub engine enable
  o_scrub_err_cnt  out  16   saturating count of uncorrectable lines found by scrub
  o_scrub_pass     out  1    one-cycle pulse on scrub address wrap

Function
REQ-004 SHALL implement FSM states IDLE, CPU, SRD, SWR.
REQ-005 IDLE: i_wb_cyc&i_wb_stb -> CPU (CPU priority); else interval counter==0 & i_scrub_en -> SRD; else stay.
REQ-006 CPU: o_m_* SHALL follow i_wb_* combinationally; o_wb_dat=i_m_dat, o_wb_ack=i_m_ack, o_wb_err=i_m_err; i_m_ack|i_m_err -> IDLE.
REQ-007 CPU request first seen in IDLE at cycle N SHALL reach o_m_stb at cycle N+1 (one-cycle arbitration latency).
REQ-008 SRD: o_m_cyc=o_m_stb=1, o_m_we=0, o_m_sel=16'hFFFF, o_m_adr=scrub_addr; on i_m_ack&~i_m_err capture i_m_dat into line buffer -> SWR.
REQ-009 SRD with i_m_err: increment o_scrub_err_cnt (saturate at 16'hFFFF), skip writeback, advance address -> IDLE.
REQ-010 SWR: o_m_we=1, o_m_sel=16'hFFFF, o_m_dat=line buffer, same address; on i_m_ack or i_m_err advance address -> IDLE.
REQ-011 Address SHALL advance by 16 (one 128-bit line); bits [3:0] and above MAIN_MSB always 0; wrap from 2^(MAIN_MSB+1)-16 to 0 with o_scrub_pass=1 that cycle.
REQ-012 Interval counter SHALL load SCRUB_INTERVAL-1 on every exit from SRD/SWR to IDLE and on reset, decrement in IDLE to 0, hold at 0.
REQ-013 CPU request arriving during SRD/SWR SHALL be held (o_wb_ack=o_wb_err=0) until scrub line completes, then granted via IDLE.
REQ-014 Outside CPU state o_wb_ack=o_wb_err=0, o_wb_dat=0; in IDLE all o_m_* =0.
REQ-015 i_scrub_en deasserted mid-scrub SHALL let current line finish; no new scrub starts.

Reset
REQ-016 i_rst SHALL force: state IDLE, scrub address 0, o_scrub_err_cnt 0, o_scrub_pass 0, line buffer 0, counter SCRUB_INTERVAL-1.
REQ-017 Reset asserted mid-transfer SHALL drop o_m_cyc/o_m_stb next edge; partial scrub not resumed.

Configuration
REQ-018 Macro EDC_SCRUB_EN: defined -> behaviour above; undefined -> no FSM/scrub logic, o_m_* = i_wb_* and o_wb_* = i_m_* combinationally (zero latency), o_scrub_err_cnt=0, o_scrub_pass=0.

Verification
REQ-019 SCRUB_INTERVAL=4, i_scrub_en=1, no CPU traffic -> read then write of 0x00000000 with identical 128-bit data, next line 0x10 after 4 idle cycles.
REQ-020 Scrub of line 0x20 returns i_m_err=1 -> no write cycle, o_scrub_err_cnt 0->1, next scrub at 0x30.
REQ-021 CPU read 0x100 asserted in same IDLE cycle counter hits 0 -> CPU granted first (o_m_stb next cycle, o_m_adr=0x100), scrub follows.
REQ-022 CPU write during SWR -> no o_wb_ack until SWR ack, CPU write reaches o_m_* one cycle after IDLE.
REQ-023 MAIN_MSB=5, scrub runs to 0x30 -> next address 0x00, o_scrub_pass pulses exactly one cycle.
REQ-024 i_rst pulse during SRD -> o_m_stb=0 next cycle, o_scrub_err_cnt=0, next scrub at 0x0 after SCRUB_INTERVAL cycles.
